// File: rtl/audio_buf_pkg.sv
// audio_buf_pkg: state encodings and default sizing shared by the audio SDRAM buffer blocks.
package audio_buf_pkg;
   localparam int DEF_ADDR_W      = 24;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_MAX_SAMPLES = 960_000;
   localparam int DEF_FIFO_DEPTH  = 4;
   typedef enum logic {W_IDLE, W_REQ} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_e;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with flush; a push into a full FIFO succeeds only alongside a pop.
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;
   assign empty   = count_q == '0;
   assign full    = count_q == CW'(DEPTH);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);
   always_comb begin
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
      count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush) mem_q[wr_ptr_q] <= din;
      end
   end
endmodule

// File: rtl/audio_sdr_buf_ctrl.sv
// audio_sdr_buf_ctrl: buffers ADC samples into sequential SDRAM words and streams them back to the DAC.
// Define AUDIO_LOOP_PLAY_EN to loop playback at the end of the recording instead of going silent.
module audio_sdr_buf_ctrl
   import audio_buf_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MAX_SAMPLES = DEF_MAX_SAMPLES,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic              clk50M,
   input  logic              reset_n,
   input  logic              record_en,
   input  logic              play_en,
   input  logic              sdr_waddr_set,
   input  logic              sdr_raddr_set,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              dac_req,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_ack,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_data_valid,
   output logic [ADDR_W-1:0] rec_len,
   output logic              overrun
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] CAP = ADDR_W'(MAX_SAMPLES);
   wr_state_e         w_st_q, w_st_d;
   rd_state_e         r_st_q, r_st_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] pf_q, pf_d, wr_data_q, wr_data_d, dac_data_q, dac_data_d, fifo_head;
   logic [CW-1:0]     fifo_count;
   logic              pf_full_q, pf_full_d, wr_stale_q, wr_stale_d, rd_stale_q, rd_stale_d;
   logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d, dac_valid_q, dac_valid_d, overrun_q, overrun_d;
   logic              push, pop, fill, consume, loop_wrap, fifo_full, fifo_empty;

   assign push    = adc_valid & record_en & !sdr_waddr_set & (waddr_q + ADDR_W'(fifo_count) < CAP);
   // A stale request (address reset while pending) completes its handshake without committing.
   assign pop     = (w_st_q == W_REQ) & wr_ack & !wr_stale_q & !sdr_waddr_set;
   assign fill    = (r_st_q == R_WAIT) & rd_data_valid & !rd_stale_q & !sdr_raddr_set;
   assign consume = dac_req & play_en & pf_full_q;
`ifdef AUDIO_LOOP_PLAY_EN
   assign loop_wrap = (r_st_q == R_IDLE) & play_en & (raddr_q == waddr_q) & (raddr_q != '0);
`else
   assign loop_wrap = 1'b0;
`endif

   sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W), .CW(CW)) u_fifo (
      .clk(clk50M), .rst_n(reset_n), .push(push), .pop(pop), .flush(sdr_waddr_set),
      .din(adc_data), .head(fifo_head), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
   );

   always_comb begin
      w_st_d    = w_st_q;
      wr_req_d  = wr_req_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (w_st_q == W_IDLE && !fifo_empty && !sdr_waddr_set) begin
         w_st_d = W_REQ; wr_req_d = 1'b1; wr_addr_d = waddr_q; wr_data_d = fifo_head;
      end else if (w_st_q == W_REQ && wr_ack) begin
         w_st_d = W_IDLE; wr_req_d = 1'b0; wr_addr_d = '0; wr_data_d = '0;
      end
      wr_stale_d = (w_st_d == W_REQ) & (wr_stale_q | sdr_waddr_set);
      waddr_d    = sdr_waddr_set ? '0 : waddr_q + ADDR_W'(pop);
      overrun_d  = !sdr_waddr_set & (overrun_q | (push & fifo_full & !pop));
      r_st_d     = r_st_q;
      rd_req_d   = rd_req_q;
      rd_addr_d  = rd_addr_q;
      if (r_st_q == R_IDLE && play_en && !sdr_raddr_set && !pf_full_q && raddr_q < waddr_q) begin
         r_st_d = R_REQ; rd_req_d = 1'b1; rd_addr_d = raddr_q;
      end else if (r_st_q == R_REQ && rd_ack) begin
         r_st_d = R_WAIT; rd_req_d = 1'b0; rd_addr_d = '0;
      end else if (r_st_q == R_WAIT && rd_data_valid) begin
         r_st_d = R_IDLE;
      end
      rd_stale_d  = (r_st_d != R_IDLE) & (rd_stale_q | sdr_raddr_set);
      raddr_d     = (sdr_raddr_set | loop_wrap) ? '0 : raddr_q + ADDR_W'(fill);
      pf_full_d   = !sdr_raddr_set & (fill | (pf_full_q & !consume));
      pf_d        = sdr_raddr_set ? '0 : fill ? rd_data : pf_q;
      dac_valid_d = dac_req;
      dac_data_d  = consume ? pf_q : '0;
   end

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         w_st_q      <= W_IDLE;
         r_st_q      <= R_IDLE;
         waddr_q     <= '0;
         raddr_q     <= '0;
         wr_req_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_stale_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         rd_addr_q   <= '0;
         rd_stale_q  <= 1'b0;
         pf_q        <= '0;
         pf_full_q   <= 1'b0;
         dac_valid_q <= 1'b0;
         dac_data_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         w_st_q      <= w_st_d;
         r_st_q      <= r_st_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         wr_req_q    <= wr_req_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_stale_q  <= wr_stale_d;
         rd_req_q    <= rd_req_d;
         rd_addr_q   <= rd_addr_d;
         rd_stale_q  <= rd_stale_d;
         pf_q        <= pf_d;
         pf_full_q   <= pf_full_d;
         dac_valid_q <= dac_valid_d;
         dac_data_q  <= dac_data_d;
         overrun_q   <= overrun_d;
      end
   end

   assign wr_req    = wr_req_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_addr_q;
   assign dac_valid = dac_valid_q;
   assign dac_data  = dac_data_q;
   assign overrun   = overrun_q;
   assign rec_len   = waddr_q;
endmodule

// File: tb/tb_audio_sdr_buf_ctrl.sv
// tb_audio_sdr_buf_ctrl: directed scenarios against a small SDRAM responder model.
module tb_audio_sdr_buf_ctrl;
   localparam int AW = 24;
   localparam int DW = 16;
   logic          clk50M = 1'b0, reset_n = 1'b0;
   logic          record_en = 1'b0, play_en = 1'b0, sdr_waddr_set = 1'b0, sdr_raddr_set = 1'b0;
   logic          adc_valid = 1'b0, dac_req = 1'b0, wr_ack = 1'b0, rd_ack = 1'b0, rd_data_valid = 1'b0;
   logic [DW-1:0] adc_data = '0, rd_data = '0;
   logic [DW-1:0] dac_data, wr_data;
   logic          dac_valid, wr_req, rd_req, overrun;
   logic [AW-1:0] wr_addr, rd_addr, rec_len;
   int            total = 0, bad = 0;
   bit            wr_auto = 1'b0, rd_auto = 1'b0;
   int            wr_once_req = 0, wr_once_done = 0, rd_delay = 2, rd_pend = 0, nw = 0, nr = 0;
   logic [AW-1:0] rd_paddr = '0;
   logic [DW-1:0] mem [16];
   logic [AW-1:0] wlog_addr [64];
   logic [DW-1:0] wlog_data [64];
   logic [AW-1:0] rlog [64];

   audio_sdr_buf_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_SAMPLES(8), .FIFO_DEPTH(4)) dut (
      .clk50M(clk50M), .reset_n(reset_n), .record_en(record_en), .play_en(play_en),
      .sdr_waddr_set(sdr_waddr_set), .sdr_raddr_set(sdr_raddr_set), .adc_valid(adc_valid),
      .adc_data(adc_data), .dac_req(dac_req), .dac_data(dac_data), .dac_valid(dac_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .rd_data_valid(rd_data_valid), .rec_len(rec_len), .overrun(overrun)
   );

   always #10 clk50M = ~clk50M;

   always @(negedge clk50M) begin
      if (wr_req && !wr_ack && (wr_auto || wr_once_req != wr_once_done)) begin
         wr_ack = 1'b1;
         if (!wr_auto) wr_once_done++;
         mem[wr_addr[3:0]] = wr_data;
         if (nw < 64) begin wlog_addr[nw] = wr_addr; wlog_data[nw] = wr_data; nw++; end
      end else wr_ack = 1'b0;
   end

   always @(negedge clk50M) begin
      rd_ack = 1'b0;
      rd_data_valid = 1'b0;
      if (rd_pend > 0) begin
         rd_pend--;
         if (rd_pend == 0) begin rd_data_valid = 1'b1; rd_data = mem[rd_paddr[3:0]]; end
      end else if (rd_req && rd_auto) begin
         rd_ack = 1'b1;
         rd_pend = rd_delay;
         rd_paddr = rd_addr;
         if (nr < 64) begin rlog[nr] = rd_addr; nr++; end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk50M);
   endtask

   task automatic pulse_dac(output logic v, output logic [DW-1:0] d, output logic v_after);
      dac_req = 1'b1;
      cyc(1);
      dac_req = 1'b0;
      v = dac_valid;
      d = dac_data;
      cyc(1);
      v_after = dac_valid;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      cyc(2);
      total++;
      if ({wr_req, rd_req, dac_valid, overrun} !== 4'b0000) begin
         bad++; $display("FAIL reset_ctl got=%b exp=0000", {wr_req, rd_req, dac_valid, overrun});
      end
      total++;
      if (rec_len !== '0 || dac_data !== '0) begin
         bad++; $display("FAIL reset_data rec_len=%0d dac_data=%h exp=0/0", rec_len, dac_data);
      end
      reset_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_record;
      int n0 = nw;
      record_en = 1'b1;
      wr_auto = 1'b1;
      for (int i = 0; i < 5; i++) begin
         adc_valid = 1'b1; adc_data = 16'h0101 + 16'(i); cyc(1);
         adc_valid = 1'b0; cyc(1);
      end
      cyc(20);
      total++;
      if (nw - n0 != 5) begin bad++; $display("FAIL rec_count got=%0d exp=5", nw - n0); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (wlog_addr[n0+i] !== AW'(i) || wlog_data[n0+i] !== 16'h0101 + 16'(i)) begin
            bad++;
            $display("FAIL rec_write%0d got=%0d/%h exp=%0d/%h", i, wlog_addr[n0+i], wlog_data[n0+i], i, 16'h0101 + 16'(i));
         end
      end
      total++;
      if (rec_len !== 24'd5) begin bad++; $display("FAIL rec_len got=%0d exp=5", rec_len); end
      total++;
      if (overrun !== 1'b0) begin bad++; $display("FAIL rec_overrun got=%b exp=0", overrun); end
      record_en = 1'b0;
      wr_auto = 1'b0;
   endtask

   task automatic test_overrun;
      sdr_waddr_set = 1'b1; cyc(1); sdr_waddr_set = 1'b0;
      record_en = 1'b1;
      adc_valid = 1'b1; adc_data = 16'h0201; cyc(1);
      adc_valid = 1'b0;
      total++;
      if (wr_req !== 1'b0) begin bad++; $display("FAIL wr_req_early got=%b exp=0", wr_req); end
      cyc(1);
      total++;
      if (wr_req !== 1'b1 || wr_addr !== '0 || wr_data !== 16'h0201) begin
         bad++; $display("FAIL wr_req_rise got=%b/%0d/%h exp=1/0/0201", wr_req, wr_addr, wr_data);
      end
      for (int i = 2; i <= 6; i++) begin
         adc_valid = 1'b1; adc_data = 16'h0200 + 16'(i); cyc(1);
      end
      adc_valid = 1'b0;
      cyc(1);
      total++;
      if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
      total++;
      if (wr_req !== 1'b1 || wr_data !== 16'h0201 || rec_len !== '0) begin
         bad++; $display("FAIL wr_hold got=%b/%h/%0d exp=1/0201/0", wr_req, wr_data, rec_len);
      end
      sdr_waddr_set = 1'b1; cyc(1); sdr_waddr_set = 1'b0;
      total++;
      if (overrun !== 1'b0 || rec_len !== '0 || wr_req !== 1'b1) begin
         bad++; $display("FAIL waddr_set got=ovr%b/len%0d/req%b exp=0/0/1", overrun, rec_len, wr_req);
      end
      wr_once_req++;
      cyc(5);
      total++;
      if (wr_req !== 1'b0 || rec_len !== '0) begin
         bad++; $display("FAIL stale_ack got=req%b/len%0d exp=0/0", wr_req, rec_len);
      end
      cyc(5);
      total++;
      if (wr_req !== 1'b0) begin bad++; $display("FAIL flushed got=%b exp=0", wr_req); end
      record_en = 1'b0;
   endtask

   task automatic test_play;
      logic v, va;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_d [4];
      int r0;
      exp_d[0] = 16'h0101; exp_d[1] = 16'h0102; exp_d[2] = 16'h0103;
`ifdef AUDIO_LOOP_PLAY_EN
      exp_d[3] = 16'h0101;
`else
      exp_d[3] = 16'h0000;
`endif
      sdr_waddr_set = 1'b1; sdr_raddr_set = 1'b1; cyc(1);
      sdr_waddr_set = 1'b0; sdr_raddr_set = 1'b0;
      record_en = 1'b1;
      wr_auto = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adc_valid = 1'b1; adc_data = 16'h0101 + 16'(i); cyc(1);
         adc_valid = 1'b0; cyc(1);
      end
      cyc(15);
      record_en = 1'b0;
      wr_auto = 1'b0;
      total++;
      if (rec_len !== 24'd3) begin bad++; $display("FAIL play_rec_len got=%0d exp=3", rec_len); end
      r0 = nr;
      rd_auto = 1'b1;
      play_en = 1'b1; cyc(10); play_en = 1'b0; cyc(2);
      pulse_dac(v, d, va);
      total++;
      if (v !== 1'b1 || d !== '0) begin bad++; $display("FAIL play_off got=%b/%h exp=1/0000", v, d); end
      play_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulse_dac(v, d, va);
         total++;
         if (v !== 1'b1 || va !== 1'b0 || d !== exp_d[i]) begin
            bad++; $display("FAIL dac%0d got=%b%b/%h exp=10/%h", i, v, va, d, exp_d[i]);
         end
         cyc(12);
      end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rlog[r0+i] !== AW'(i)) begin bad++; $display("FAIL rd_addr%0d got=%0d exp=%0d", i, rlog[r0+i], i); end
      end
      play_en = 1'b0;
      cyc(10);
   endtask

   task automatic test_raddr_set;
      logic v, va;
      logic [DW-1:0] d;
      int r0;
      sdr_raddr_set = 1'b1; cyc(1); sdr_raddr_set = 1'b0;
      rd_delay = 8;
      r0 = nr;
      play_en = 1'b1;
      for (int i = 0; i < 20 && nr == r0; i++) cyc(1);
      total++;
      if (nr == r0) begin bad++; $display("FAIL rd_issue got=none exp=request"); end
      cyc(3);
      sdr_raddr_set = 1'b1; cyc(1); sdr_raddr_set = 1'b0;
      rd_delay = 2;
      cyc(25);
      total++;
      if (nr - r0 < 2 || rlog[r0] !== '0 || rlog[r0+1] !== '0) begin
         bad++; $display("FAIL refetch got=n%0d/%0d/%0d exp=2+/0/0", nr - r0, rlog[r0], rlog[r0+1]);
      end
      pulse_dac(v, d, va);
      total++;
      if (d !== 16'h0101) begin bad++; $display("FAIL after_rset0 got=%h exp=0101", d); end
      cyc(10);
      pulse_dac(v, d, va);
      total++;
      if (d !== 16'h0102) begin bad++; $display("FAIL after_rset1 got=%h exp=0102", d); end
      play_en = 1'b0;
      cyc(10);
   endtask

   task automatic test_async_reset;
      sdr_raddr_set = 1'b1; cyc(1); sdr_raddr_set = 1'b0;
      rd_auto = 1'b0;
      wr_auto = 1'b0;
      play_en = 1'b1;
      record_en = 1'b1;
      adc_valid = 1'b1; adc_data = 16'h0301; cyc(1);
      adc_valid = 1'b0;
      cyc(3);
      total++;
      if (wr_req !== 1'b1 || rd_req !== 1'b1 || wr_addr !== 24'd3 || wr_data !== 16'h0301) begin
         bad++; $display("FAIL pre_reset got=%b%b/%0d/%h exp=11/3/0301", wr_req, rd_req, wr_addr, wr_data);
      end
      #3 reset_n = 1'b0;
      #1;
      total++;
      if ({wr_req, rd_req, dac_valid, overrun} !== 4'b0000) begin
         bad++; $display("FAIL async_ctl got=%b exp=0000", {wr_req, rd_req, dac_valid, overrun});
      end
      total++;
      if (wr_addr !== '0 || wr_data !== '0 || rd_addr !== '0 || rec_len !== '0 || dac_data !== '0) begin
         bad++; $display("FAIL async_data got=%0d/%h/%0d/%0d/%h exp=0", wr_addr, wr_data, rd_addr, rec_len, dac_data);
      end
      play_en = 1'b0;
      record_en = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      cyc(6);
      total++;
      if (wr_req !== 1'b0 || rd_req !== 1'b0 || rec_len !== '0) begin
         bad++; $display("FAIL post_reset got=%b%b/%0d exp=00/0", wr_req, rd_req, rec_len);
      end
      rd_auto = 1'b1;
   endtask

   task automatic test_capacity;
      int n0;
      sdr_waddr_set = 1'b1; cyc(1); sdr_waddr_set = 1'b0;
      n0 = nw;
      wr_auto = 1'b1;
      record_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         adc_valid = 1'b1; adc_data = 16'h0401 + 16'(i); cyc(1);
         adc_valid = 1'b0; cyc(3);
      end
      cyc(15);
      total++;
      if (nw - n0 != 8) begin bad++; $display("FAIL cap_count got=%0d exp=8", nw - n0); end
      total++;
      if (rec_len !== 24'd8) begin bad++; $display("FAIL cap_len got=%0d exp=8", rec_len); end
      total++;
      if (overrun !== 1'b0) begin bad++; $display("FAIL cap_overrun got=%b exp=0", overrun); end
      total++;
      if (wlog_addr[n0+7] !== 24'd7 || wlog_data[n0+7] !== 16'h0408) begin
         bad++; $display("FAIL cap_last got=%0d/%h exp=7/0408", wlog_addr[n0+7], wlog_data[n0+7]);
      end
      record_en = 1'b0;
      wr_auto = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      test_reset();
      test_record();
      test_overrun();
      test_play();
      test_raddr_set();
      test_async_reset();
      test_capacity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/audio_sdr_buf_ctrl.md
# audio_sdr_buf_ctrl

Consumer side of the key-detector control signals in the audio record/playback demo. It takes `record_en`, `play_en`, `sdr_waddr_set` and `sdr_raddr_set`, buffers ADC samples and writes them to sequential SDRAM addresses. It also reads the recorded samples back for the DAC and reports the recorded length. It sits between the codec interface and the SDRAM controller's simple request/acknowledge ports.

## Interface
- `ADDR_W`, 24, SDRAM word-address width.
- `DATA_W`, 16, sample width.
- `MAX_SAMPLES`, 960_000, recording capacity in samples (20 s at 48 kHz); must be < 2^ADDR_W.
- `FIFO_DEPTH`, 4, write-side sample FIFO depth (power of two).

Ports:
- `clk50M` in 1: single clock, 50 MHz.
- `reset_n` in 1: asynchronous active-low reset.
- `record_en` in 1: level; accept ADC samples while high.
- `play_en` in 1: level; fetch and serve samples while high.
- `sdr_waddr_set` in 1: level; while high, hold the write address at 0.
- `sdr_raddr_set` in 1: level; while high, hold the read address at 0.
- `adc_valid` in 1: 1-cycle strobe; `adc_data` is valid.
- `adc_data` in DATA_W: ADC sample.
- `dac_req` in 1: 1-cycle strobe requesting the next playback sample.
- `dac_data` out DATA_W: playback sample.
- `dac_valid` out 1: 1-cycle strobe; `dac_data` is valid.
- `wr_req` out 1, `wr_addr` out ADDR_W, `wr_data` out DATA_W, `wr_ack` in 1: SDRAM write port.
- `rd_req` out 1, `rd_addr` out ADDR_W, `rd_ack` in 1, `rd_data` in DATA_W, `rd_data_valid` in 1: SDRAM read port.
- `rec_len` out ADDR_W: number of samples committed to SDRAM (equal to waddr).
- `overrun` out 1: sticky flag; a sample was dropped because the FIFO was full.

## Operation
- Reset sets every output, waddr, raddr, FIFO, prefetch register and both FSMs to 0 / idle.
- **Push:** `adc_valid & record_en & !sdr_waddr_set & (waddr + fifo_count < MAX_SAMPLES)`.
  - If the FIFO is full and no pop occurs that cycle, drop the sample and set `overrun`.
  - Push and pop in the same cycle on a full FIFO: the sample is accepted.
  - At capacity, the sample is ignored silently and `overrun` is unchanged.
- **Write FSM:**
  - W_IDLE → W_REQ when the FIFO is non-empty. Drive `wr_req=1`, `wr_addr=waddr`, `wr_data=FIFO head`.
  - Hold all three stable until `wr_ack`.
  - On `wr_ack`: pop the FIFO, increment waddr, return to W_IDLE.
- **`sdr_waddr_set` high:**
  - waddr=0, FIFO flushed, `overrun` cleared.
  - A request already in W_REQ stays asserted until `wr_ack`; that ack is discarded, with no increment and no pop.
- **Read FSM:** R_IDLE → R_REQ → R_WAIT.
  - R_IDLE → R_REQ when `play_en & !sdr_raddr_set & prefetch empty & raddr < waddr`. Drive `rd_req=1`, `rd_addr=raddr`.
  - R_REQ: hold until `rd_ack`, then go to R_WAIT.
  - R_WAIT: on `rd_data_valid`, capture `rd_data` into the prefetch register, increment raddr, go to R_IDLE.
- **`sdr_raddr_set` high:**
  - raddr=0 and the prefetch register is emptied.
  - An in-flight read completes its handshake; the returned data is discarded.
- **DAC service on `dac_req`:**
  - If `play_en` is high and the prefetch register was full at the start of the cycle: output the prefetched sample and empty the register.
  - Otherwise: output `dac_data=0` (silence). `dac_valid` is still pulsed.
  - A prefetch fill in the same cycle as `dac_req` serves the next `dac_req`, not this one.
- **End of recording:** when raddr == waddr, no further reads are issued; see Configuration.
- **Arithmetic:** all address arithmetic is ADDR_W unsigned. waddr saturates at MAX_SAMPLES because of the push guard.

## Timing
- `adc_valid` at edge N → sample in FIFO after N → `wr_req` high after edge N+1 at the earliest.
- `wr_ack` at edge M → `wr_req` low after M. The next request can rise after M+1 at the earliest.
- `rd_req` rises one edge after its condition becomes true and falls on the `rd_ack` edge.
- `dac_req` at edge N → `dac_valid=1` and `dac_data` valid for exactly the cycle after N.
- `rec_len` updates on the same edge as the `wr_ack` that commits the sample.

## Configuration
- Macro `AUDIO_LOOP_PLAY_EN`.
- **Defined:** when raddr == waddr, raddr != 0 and `play_en` is high, raddr wraps to 0 and fetching continues, so playback loops while `play_en` is held.
- **Undefined:** playback stops at the end of the recording; subsequent `dac_req` return silence.

## Structure
- Package `audio_buf_pkg` holds:
  - write FSM state encoding: W_IDLE, W_REQ;
  - read FSM state encoding: R_IDLE, R_REQ, R_WAIT;
  - default width and capacity constants.
- One sub-module, `sample_fifo`: synchronous FIFO parameterised by depth and width, with push, pop, flush, head, count, full and empty.

## Test plan
- Record 5 samples 0x0101..0x0105 with immediate `wr_ack` → writes to addresses 0..4 with matching data; `rec_len=5`; `overrun=0`.
- Hold `wr_ack` low and push 6 samples → first 4 accepted (FIFO full), last 2 dropped; `overrun=1`; `sdr_waddr_set` pulse clears it and `rec_len=0`.
- After recording 3 samples, assert `play_en` and issue 4 `dac_req` → `dac_data` 0x0101, 0x0102, 0x0103, then 0 (loop macro off) or 0x0101 (loop macro on).
- Assert `sdr_raddr_set` while in R_WAIT → returned data discarded, raddr=0; the next fetch reads address 0.
- Set `MAX_SAMPLES=8` and push 10 samples with `record_en` → exactly 8 written; `rec_len=8`; `overrun=0`.
- Assert `reset_n` low mid-transaction (W_REQ and R_REQ) → all outputs 0 immediately (asynchronous); FSMs idle.
